key_debounce_n: RTL and testbench

KEY_DEBOUNCE_N -- requirements
Module: key_debounce_n

---
 rtl/key_debounce_n.sv | 177 +++++++++++++++++
 tb/tb_key_debounce_n.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_n.sv
// key_debounce_n -- multi-channel key debouncer.
// Each active-low key input passes through a two-flop synchroniser into a
// four-state filter FSM (IDLE, FILTER0, DOWN, FILTER1) that reports a clean
// pressed level plus one-cycle press/release pulses.
// Optional long-press pulse: define KEY_LONG_PRESS_EN to build the hold
// counter; without it key_long is tied to 0.
module key_debounce_n #(
    parameter int N_KEYS      = 4,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILTER0 = 2'd1,
        DOWN    = 2'd2,
        FILTER1 = 2'd3
    } state_t;

    localparam int            CW      = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    // Reject configurations the filter cannot honour.
    if (N_KEYS < 1 || N_KEYS > 32 || DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES) begin : g_bad_cfg
        $error("key_debounce_n: illegal parameter combination");
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        logic [1:0]    sync_q, sync_d;
        logic          s;
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          key_state_q, key_state_d;
        logic          press_q, press_d;
        logic          release_q, release_d;

        assign s = sync_q[1];

        // Shift the raw key level through the synchroniser.
        always_comb begin
            sync_d = {sync_q[0], key_in[g]};
        end

        // Filter FSM: a level change must hold for DEB_CYCLES samples to count.
        always_comb begin
            // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
            state_d     = state_q;
            cnt_d       = cnt_q;
            key_state_d = key_state_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!s) begin
                        state_d = FILTER0;
                        cnt_d   = '0;
                    end
                end
                FILTER0: begin
                    if (s) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d     = DOWN;
                        key_state_d = 1'b1;
                        press_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DOWN: begin
                    if (s) begin
                        state_d = FILTER1;
                        cnt_d   = '0;
                    end
                end
                FILTER1: begin
                    if (!s) begin
                        state_d = DOWN;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d     = IDLE;
                        key_state_d = 1'b0;
                        release_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    key_state_d = 1'b0;
                end
            endcase
        end

        // Channel registers; reset parks the synchroniser at the released level.
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            if (rst) begin
                sync_q      <= 2'b11;
                state_q     <= IDLE;
                cnt_q       <= '0;
                key_state_q <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
            end else begin
                sync_q      <= sync_d;
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                key_state_q <= key_state_d;
                press_q     <= press_d;
                release_q   <= release_d;
            end
        end

        assign key_state[g]   = key_state_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;

`ifdef KEY_LONG_PRESS_EN
        localparam int            HW       = $clog2(LONG_CYCLES);
        localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

        logic [HW-1:0] hold_q, hold_d;
        logic          fired_q, fired_d;
        logic          long_q, long_d;

        // Hold counter runs while pressed; the pulse fires once it has saturated.
        always_comb begin
            hold_d  = hold_q;
            fired_d = fired_q;
            long_d  = 1'b0;
            if (state_q == FILTER0 && state_d == DOWN) begin
                hold_d  = '0;
                fired_d = 1'b0;
            end else if (state_q == DOWN || state_q == FILTER1) begin
                if (hold_q == HOLD_MAX) begin
                    if (!fired_q) begin
                        long_d  = 1'b1;
                        fired_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            if (state_d == IDLE) begin
                hold_d = '0;
            end
        end

        // Long-press registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q  <= '0;
                fired_q <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                hold_q  <= hold_d;
                fired_q <= fired_d;
                long_q  <= long_d;
            end
        end

        assign key_long[g] = long_q;
`else
        assign key_long[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_debounce_n.sv
// tb_key_debounce_n -- directed and randomized checks of key_debounce_n
// against a run-length reference model. Honours KEY_LONG_PRESS_EN.
module tb_key_debounce_n;

    localparam int N    = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key_in;
    logic [N-1:0] key_state, key_press, key_release, key_long;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: per channel a 2-sample input delay, the debounced
    // level, the length of the current run of samples disagreeing with it,
    // and the number of edges spent pressed since the last press.
    logic [N-1:0] m_state, m_press, m_rel, m_long;
    bit           h1[N], h2[N];
    int           run[N], age[N];

    key_debounce_n #(
        .N_KEYS     (N),
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

    function automatic void model_edge(input logic [N-1:0] k, input logic r);
        for (int i = 0; i < N; i++) begin
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            m_long[i]  = 1'b0;
            if (r) begin
                h1[i]      = 1'b1;
                h2[i]      = 1'b1;
                m_state[i] = 1'b0;
                run[i]     = 0;
                age[i]     = 0;
            end else begin
                bit s;
                bit want;
                s     = h2[i];
                h2[i] = h1[i];
                h1[i] = k[i];
                want  = !s;
                if (m_state[i]) begin
                    age[i]++;
                    if (LONG_EN && age[i] == LONG) m_long[i] = 1'b1;
                end
                if (want == m_state[i]) begin
                    run[i] = 0;
                end else begin
                    run[i]++;
                    if (run[i] == DEB + 1) begin
                        m_state[i] = want;
                        run[i]     = 0;
                        m_press[i] = want;
                        m_rel[i]   = !want;
                        if (want) age[i] = 0;
                    end
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Apply inputs for one clock, advance the model, compare all outputs.
    task automatic step(input logic [N-1:0] k, input logic r);
        key_in = k;
        rst    = r;
        @(posedge clk);
        model_edge(k, r);
        #1;
        cyc++;
        check("state",   32'(key_state),   32'(m_state));
        check("press",   32'(key_press),   32'(m_press));
        check("release", 32'(key_release), 32'(m_rel));
        check("long",    32'(key_long),    32'(m_long));
    endtask

    initial begin
        int first_press;
        int first_rel;
        int long_cnt;
        int long_at;
        int rel_seen;
        int dropped;
        logic [N-1:0] lvl;
        int remain[N];

        key_in = '1;
        rst    = 1'b1;

        // Reset.
        repeat (3) step('1, 1'b1);
        check("reset_outputs", 32'({key_state, key_press, key_release, key_long}), 32'd0);
        repeat (2) step('1, 1'b0);

        // Clean press on ch0 held 40 cycles (also the long-press window).
        first_press = -1;
        long_cnt    = 0;
        long_at     = -1;
        for (int c = 1; c <= 40; c++) begin
            step(2'b10, 1'b0);
            if (key_press[0] && first_press < 0) first_press = c;
            if (key_long[0]) begin
                long_cnt++;
                long_at = c;
            end
            if (c == 7) check("press_c7", 32'({key_state[0], key_press[0]}), 32'b11);
            if (c == 8) check("press_c8", 32'({key_state[0], key_press[0]}), 32'b10);
        end
        check("press_latency", 32'(first_press), 32'd7);
        check("long_count", 32'(long_cnt), LONG_EN ? 32'd1 : 32'd0);
        check("long_cycle", 32'(long_at), LONG_EN ? 32'(7 + LONG) : 32'hFFFF_FFFF);

        // Release glitch: 2 high cycles must not release.
        rel_seen = 0;
        dropped  = 0;
        for (int c = 1; c <= 12; c++) begin
            step((c <= 2) ? 2'b11 : 2'b10, 1'b0);
            if (key_release[0]) rel_seen++;
            if (!key_state[0]) dropped++;
        end
        check("glitch_no_release", 32'(rel_seen), 32'd0);
        check("glitch_state_held", 32'(dropped), 32'd0);

        // Stable release.
        first_rel = -1;
        for (int c = 1; c <= 10; c++) begin
            step(2'b11, 1'b0);
            if (key_release[0] && first_rel < 0) first_rel = c;
        end
        check("release_latency", 32'(first_rel), 32'd7);
        check("released_state", 32'(key_state), 32'd0);

        // Bounce reject: low 3, high 1, low again.
        first_press = -1;
        for (int c = 1; c <= 16; c++) begin
            step((c == 4) ? 2'b11 : 2'b10, 1'b0);
            if (key_press[0] && first_press < 0) first_press = c;
        end
        check("bounce_press_cycle", 32'(first_press), 32'd11);
        repeat (10) step(2'b11, 1'b0);

        // Independent channels: both press, then only ch1 releases.
        for (int c = 1; c <= 10; c++) begin
            step(2'b00, 1'b0);
            if (c == 7) check("dual_press", 32'(key_press), 32'b11);
        end
        for (int c = 1; c <= 10; c++) begin
            step(2'b10, 1'b0);
            if (c == 7) check("ch1_release", 32'(key_release), 32'b10);
        end
        check("ch0_still_down", 32'(key_state), 32'b01);

        // Reset mid-press: outputs clear with no release, then re-debounce.
        step(2'b10, 1'b1);
        check("midreset_outputs", 32'({key_state, key_release}), 32'd0);
        first_press = -1;
        rel_seen    = 0;
        for (int c = 1; c <= 10; c++) begin
            step(2'b10, 1'b0);
            if (key_press[0] && first_press < 0) first_press = c;
            if (key_release != '0) rel_seen++;
        end
        check("post_reset_press", 32'(first_press), 32'd7);
        check("post_reset_no_rel", 32'(rel_seen), 32'd0);

        // Randomized run lengths: mostly short bounces, sometimes long holds.
        lvl = '1;
        for (int i = 0; i < N; i++) remain[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                remain[i]--;
                if (remain[i] <= 0) begin
                    lvl[i]    = ~lvl[i];
                    remain[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                            : int'($urandom_range(1, 8));
                end
            end
            step(lvl, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
